// File: rtl/neural_pkg.sv
// Shared opcodes, FSM state type and width helpers for the neural MAC engine.
package neural_pkg;

   localparam logic [7:0] OP_LOAD_W = 8'hA1;
   localparam logic [7:0] OP_LOAD_X = 8'hA2;
   localparam logic [7:0] OP_RESEND = 8'hA3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_W = 3'd1,
      ST_LOAD_X = 3'd2,
      ST_MAC    = 3'd3,
      ST_DONE   = 3'd4,
      ST_TX     = 3'd5
   } state_e;

   // Accumulator width: 16-bit products plus growth for COLS terms, never below 17.
   function automatic int acc_width(input int cols);
      int w;
      w = 16 + $clog2(cols);
      return (w < 17) ? 17 : w;
   endfunction

   // Bytes per transmitted result (accumulator rounded up to whole bytes).
   function automatic int res_bytes(input int cols);
      return (acc_width(cols) + 7) / 8;
   endfunction

   // Index width for an n-entry array; at least one bit so single-entry arrays stay legal.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/neural_mac_engine_if.sv
// UART-side byte bus of the neural MAC engine.
// RX: RX_VALID is a one-cycle strobe with no backpressure; RX_ERROR flags a framing error.
// TX: a byte moves when TX_VALID && TX_READY at a rising clock edge; while TX_VALID is high
//     and TX_READY is low, TX_DATA must not change and TX_VALID must not drop.
interface neural_mac_engine_if;
   logic [7:0] RX_DATA;
   logic       RX_VALID;
   logic       RX_ERROR;
   logic [7:0] TX_DATA;
   logic       TX_VALID;
   logic       TX_READY;

   // UART side: supplies received bytes, consumes result bytes.
   modport master (output RX_DATA, RX_VALID, RX_ERROR, TX_READY,
                   input  TX_DATA, TX_VALID);

   // Engine side.
   modport slave  (input  RX_DATA, RX_VALID, RX_ERROR, TX_READY,
                   output TX_DATA, TX_VALID);
endinterface

// File: rtl/neural_mac.sv
// Time-shared multiply-accumulate: registered 8x8 product followed by an ACC_W accumulator.
// sum_o is the accumulator value including the product currently in the pipeline register,
// so a finished row can be captured in the same cycle its last product is added.
module neural_mac
   import neural_pkg::*;
#(
   parameter int ACC_W  = 17,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [7:0]       a_i,
   input  logic [7:0]       b_i,
   output logic [ACC_W-1:0] sum_o
);

   logic signed [8:0]  a_x, b_x;
   logic signed [17:0] prod;
   logic signed [17:0] p_q;
   logic               vld_q, clr_q;
   logic [ACC_W-1:0]   acc_q, p_ext, base;

   // Operands become 9-bit signed values: sign bit copied in signed mode, zero otherwise.
   assign a_x  = {(SIGNED != 0) && a_i[7], a_i};
   assign b_x  = {(SIGNED != 0) && b_i[7], b_i};
   assign prod = 18'(a_x) * 18'(b_x);

   assign p_ext = ACC_W'(p_q);
   assign base  = clr_q ? '0 : acc_q;
   assign sum_o = base + p_ext;

   // Product register and accumulator; the clear flag travels with its product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q   <= '0;
         vld_q <= 1'b0;
         clr_q <= 1'b0;
         acc_q <= '0;
      end else begin
         vld_q <= en_i;
         clr_q <= clr_i;
         if (en_i)  p_q   <= prod;
         if (vld_q) acc_q <= sum_o;
      end
   end

endmodule

// File: rtl/neural_mac_engine.sv
// Neural MAC engine: loads a ROWS x COLS weight matrix and a COLS input vector from the
// UART byte stream, computes the matrix-vector product on one MAC unit and streams each
// result back MSB byte first.
module neural_mac_engine
   import neural_pkg::*;
#(
   parameter int ROWS   = 2,
   parameter int COLS   = 2,
   parameter int SIGNED = 0
) (
   input  logic                CLK,
   input  logic                RESET,
   neural_mac_engine_if.slave  bus,
   output logic                LOAD_ARR,
   output logic                MULT_DONE,
   output logic                ERR,
   output state_e              dbg_state_o
);

   localparam int ACC_W     = acc_width(COLS);
   localparam int RES_BYTES = res_bytes(COLS);
   localparam int EXT_W     = RES_BYTES * 8;
   localparam int PAD_W     = EXT_W - ACC_W;
   localparam int W_N       = ROWS * COLS;
   localparam int W_IW      = idx_width(W_N);
   localparam int X_IW      = idx_width(COLS);
   localparam int R_IW      = idx_width(ROWS);

   localparam logic [W_IW-1:0] W_LAST    = W_IW'(W_N - 1);
   localparam logic [W_IW-1:0] X_LAST    = W_IW'(COLS - 1);
   localparam logic [X_IW-1:0] COL_LAST  = X_IW'(COLS - 1);
   localparam logic [R_IW-1:0] ROW_LAST  = R_IW'(ROWS - 1);
   localparam logic [1:0]      BYTE_LAST = 2'(RES_BYTES - 1);

   state_e            state_q, state_d;
   logic [W_IW-1:0]   idx_q, idx_d;
   logic [R_IW-1:0]   row_q, row_d, txr_q, txr_d, wr_row_q, wr_row_d;
   logic [X_IW-1:0]   col_q, col_d;
   logic [1:0]        txb_q, txb_d;
   logic              err_q, err_d, wr_q, wr_d;
   logic              w_we, x_we, rx_take;

   logic [7:0]        w_q   [2**W_IW];
   logic [7:0]        x_q   [2**X_IW];
   logic [ACC_W-1:0]  res_q [2**R_IW];

   logic [ACC_W-1:0]  mac_sum;
   logic [EXT_W-1:0]  tx_word;
   logic [7:0]        tx_byte;

   // A byte that arrives together with a framing error is discarded.
   assign rx_take = bus.RX_VALID && !bus.RX_ERROR;

   neural_mac #(.ACC_W(ACC_W), .SIGNED(SIGNED)) u_mac (
      .clk   (CLK),
      .rst   (RESET),
      .en_i  (state_q == ST_MAC),
      .clr_i (col_q == '0),
      .a_i   (w_q[idx_q]),
      .b_i   (x_q[col_q]),
      .sum_o (mac_sum)
   );

   // FSM state, counters, sticky error and the row-complete tag that trails the MAC pipeline.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         row_q    <= '0;
         col_q    <= '0;
         txr_q    <= '0;
         txb_q    <= '0;
         err_q    <= 1'b0;
         wr_q     <= 1'b0;
         wr_row_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         row_q    <= row_d;
         col_q    <= col_d;
         txr_q    <= txr_d;
         txb_q    <= txb_d;
         err_q    <= err_d;
         wr_q     <= wr_d;
         wr_row_q <= wr_row_d;
      end
   end

   // Next-state logic: opcode decode, array loading, MAC sequencing and TX walk.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      row_d    = row_q;
      col_d    = col_q;
      txr_d    = txr_q;
      txb_d    = txb_q;
      err_d    = err_q;
      wr_d     = 1'b0;
      wr_row_d = row_q;
      w_we     = 1'b0;
      x_we     = 1'b0;
      if (bus.RX_ERROR) err_d = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            if (rx_take) begin
               unique case (bus.RX_DATA)
                  OP_LOAD_W: begin state_d = ST_LOAD_W; idx_d = '0; err_d = 1'b0; end
                  OP_LOAD_X: begin state_d = ST_LOAD_X; idx_d = '0; err_d = 1'b0; end
                  OP_RESEND: begin state_d = ST_TX; txr_d = '0; txb_d = '0; err_d = 1'b0; end
                  default:   err_d = 1'b1;
               endcase
            end
         end
         ST_LOAD_W: begin
            if (bus.RX_ERROR) begin
               state_d = ST_IDLE;
            end else if (rx_take) begin
               w_we = 1'b1;
               if (idx_q == W_LAST) begin state_d = ST_IDLE; idx_d = '0; end
               else idx_d = idx_q + 1'b1;
            end
         end
         ST_LOAD_X: begin
            if (bus.RX_ERROR) begin
               state_d = ST_IDLE;
            end else if (rx_take) begin
               x_we = 1'b1;
               if (idx_q == X_LAST) begin
                  state_d = ST_MAC;
                  idx_d   = '0;
                  row_d   = '0;
                  col_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_MAC: begin
            if (bus.RX_VALID) err_d = 1'b1;
            wr_d  = (col_q == COL_LAST);
            idx_d = idx_q + 1'b1;
            if (col_q == COL_LAST) begin
               col_d = '0;
               if (row_q == ROW_LAST) begin state_d = ST_DONE; idx_d = '0; end
               else row_d = row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.RX_VALID) err_d = 1'b1;
            state_d = ST_TX;
            txr_d   = '0;
            txb_d   = '0;
         end
         ST_TX: begin
            if (bus.RX_VALID) err_d = 1'b1;
            if (bus.TX_READY) begin
               if (txb_q == BYTE_LAST) begin
                  txb_d = '0;
                  if (txr_q == ROW_LAST) state_d = ST_IDLE;
                  else txr_d = txr_q + 1'b1;
               end else begin
                  txb_d = txb_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Storage: weight/input bytes during loads, a row result when its last product is summed.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         w_q   <= '{default: '0};
         x_q   <= '{default: '0};
         res_q <= '{default: '0};
      end else begin
         if (w_we) w_q[idx_q] <= bus.RX_DATA;
         if (x_we) x_q[idx_q[X_IW-1:0]] <= bus.RX_DATA;
         if (wr_q) res_q[wr_row_q] <= mac_sum;
      end
   end

   // Extend the selected result to whole bytes and pick the current byte, MSB first.
   always_comb begin
      if (SIGNED != 0) tx_word = {{PAD_W{res_q[txr_q][ACC_W-1]}}, res_q[txr_q]};
      else             tx_word = {{PAD_W{1'b0}}, res_q[txr_q]};
      tx_byte = '0;
      for (int b = 0; b < RES_BYTES; b++) begin
         if (txb_q == 2'(RES_BYTES - 1 - b)) tx_byte = tx_word[8*b +: 8];
      end
   end

   assign bus.TX_VALID = (state_q == ST_TX);
   assign bus.TX_DATA  = (state_q == ST_TX) ? tx_byte : 8'h00;
   assign LOAD_ARR     = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_X);
   assign MULT_DONE    = (state_q == ST_DONE);
   assign ERR          = err_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_neural_mac_engine.sv
// Directed bench for neural_mac_engine: one unsigned and one signed 2x2 instance share the
// stimulus drivers; 'sel' routes the drivers and the observed outputs to one of them.
module tb_neural_mac_engine;
   import neural_pkg::*;

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   // ---------------- stimulus and routing ----------------
   logic       sel;
   logic [7:0] rx_data;
   logic       rx_valid, rx_error, tx_ready;

   neural_mac_engine_if bus_u ();
   neural_mac_engine_if bus_s ();

   assign bus_u.RX_DATA  = rx_data;
   assign bus_u.RX_VALID = rx_valid & ~sel;
   assign bus_u.RX_ERROR = rx_error & ~sel;
   assign bus_u.TX_READY = tx_ready & ~sel;
   assign bus_s.RX_DATA  = rx_data;
   assign bus_s.RX_VALID = rx_valid & sel;
   assign bus_s.RX_ERROR = rx_error & sel;
   assign bus_s.TX_READY = tx_ready & sel;

   logic   la_u, md_u, err_u, la_s, md_s, err_s;
   state_e st_u, st_s;

   neural_mac_engine #(.ROWS(2), .COLS(2), .SIGNED(0)) u_dut_u (
      .CLK(CLK), .RESET(RESET), .bus(bus_u),
      .LOAD_ARR(la_u), .MULT_DONE(md_u), .ERR(err_u), .dbg_state_o(st_u)
   );

   neural_mac_engine #(.ROWS(2), .COLS(2), .SIGNED(1)) u_dut_s (
      .CLK(CLK), .RESET(RESET), .bus(bus_s),
      .LOAD_ARR(la_s), .MULT_DONE(md_s), .ERR(err_s), .dbg_state_o(st_s)
   );

   logic [7:0] tx_data;
   logic       tx_valid, load_arr, mult_done, err;
   state_e     st;
   assign tx_data   = sel ? bus_s.TX_DATA  : bus_u.TX_DATA;
   assign tx_valid  = sel ? bus_s.TX_VALID : bus_u.TX_VALID;
   assign load_arr  = sel ? la_s  : la_u;
   assign mult_done = sel ? md_s  : md_u;
   assign err       = sel ? err_s : err_u;
   assign st        = sel ? st_s  : st_u;

   int done_cnt = 0;
   always @(negedge CLK) if (mult_done) done_cnt++;

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_res(input logic [23:0] r);
      exp_q.push_back(r[23:16]);
      exp_q.push_back(r[15:8]);
      exp_q.push_back(r[7:0]);
   endtask

   // ---------------- drivers (all called at #1 after a rising edge) ----------------
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic pulse_rx_error();
      rx_error = 1'b1;
      step();
      rx_error = 1'b0;
   endtask

   // Drain the expected queue from the TX port; optionally randomise TX_READY.
   task automatic collect_tx(input string tag, input bit rnd);
      int         n;
      int         got_n;
      int         budget;
      bit         stalled;
      logic [7:0] held;
      logic [7:0] e;
      n       = exp_q.size();
      got_n   = 0;
      budget  = 0;
      stalled = 1'b0;
      held    = '0;
      while (got_n < n && budget < 500) begin
         step();
         budget++;
         tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (tx_valid) begin
            if (stalled) check({tag, "_stable"}, tx_data, held);
            if (tx_ready) begin
               e = exp_q.pop_front();
               check({tag, "_byte"}, tx_data, e);
               got_n++;
               stalled = 1'b0;
            end else begin
               held    = tx_data;
               stalled = 1'b1;
            end
         end
      end
      if (got_n < n) check({tag, "_timeout"}, got_n, n);
      exp_q.delete();
      step();
      tx_ready = 1'b0;
      check({tag, "_end_valid"}, tx_valid, 1'b0);
      check({tag, "_end_idle"}, st, ST_IDLE);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int md_k, tv_k, d0;
      sel = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_error = 1'b0; tx_ready = 1'b0;
      RESET = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b0;
      step();

      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_load_arr", load_arr, 1'b0);
      check("rst_mult_done", mult_done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_state_u", st_u, ST_IDLE);
      check("rst_state_s", st_s, ST_IDLE);

      // Unsigned 2x2: [[1,2],[3,4]] * [5,6] = [17, 39]
      d0 = done_cnt;
      send_byte(8'hA1);
      check("t1_load_arr_rise", load_arr, 1'b1);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      check("t1_load_arr_fall", load_arr, 1'b0);
      send_byte(8'hA2); send_byte(8'h05); send_byte(8'h06);
      md_k = 0;
      tv_k = 0;
      for (int k = 1; k <= 20; k++) begin
         if (mult_done && md_k == 0) md_k = k;
         if (tx_valid) begin tv_k = k; break; end
         step();
      end
      check("t1_mult_done_lat", md_k, 5);
      check("t1_tx_valid_lat", tv_k, 6);
      push_res(24'd17);
      push_res(24'd39);
      collect_tx("t1", 1'b0);
      check("t1_done_pulses", done_cnt - d0, 1);

      // Signed 2x2: [[-1,2],[-128,127]] * [-128,127] = [382, 32513]
      sel = 1'b1;
      d0 = done_cnt;
      send_byte(8'hA1);
      send_byte(8'hFF); send_byte(8'h02); send_byte(8'h80); send_byte(8'h7F);
      send_byte(8'hA2); send_byte(8'h80); send_byte(8'h7F);
      push_res(24'h00017E);
      push_res(24'h007F01);
      collect_tx("t2", 1'b0);
      check("t2_done_pulses", done_cnt - d0, 1);

      // Unsigned all 0xFF: each row 2*255*255 = 0x1FC02, zero-extended; random TX_READY
      sel = 1'b0;
      send_byte(8'hA1);
      for (int i = 0; i < 4; i++) send_byte(8'hFF);
      send_byte(8'hA2); send_byte(8'hFF); send_byte(8'hFF);
      push_res(24'h01FC02);
      push_res(24'h01FC02);
      collect_tx("t3", 1'b1);

      // Unknown opcode sets ERR; RESEND clears it and replays the stored results
      send_byte(8'h55);
      check("t4_err_set", err, 1'b1);
      check("t4_state_idle", st, ST_IDLE);
      send_byte(8'hA3);
      check("t4_err_clr", err, 1'b0);
      push_res(24'h01FC02);
      push_res(24'h01FC02);
      collect_tx("t4", 1'b0);

      // RX_ERROR after two LOAD_W bytes aborts; weights become [1,1,FF,FF]
      d0 = done_cnt;
      send_byte(8'hA1); send_byte(8'h01); send_byte(8'h01);
      pulse_rx_error();
      check("t5_err", err, 1'b1);
      check("t5_load_arr", load_arr, 1'b0);
      check("t5_state", st, ST_IDLE);
      repeat (6) step();
      check("t5_no_done_w", done_cnt - d0, 0);
      // RX_ERROR inside LOAD_X starts no compute
      send_byte(8'hA2); send_byte(8'h09);
      pulse_rx_error();
      check("t5x_state", st, ST_IDLE);
      repeat (6) step();
      check("t5_no_done_x", done_cnt - d0, 0);
      // x = [2,3] -> [5, 1275]; a byte arriving during MAC is dropped
      send_byte(8'hA2); send_byte(8'h02); send_byte(8'h03);
      send_byte(8'hA1);
      check("t5_overrun_err", err, 1'b1);
      check("t5_overrun_state", st, ST_MAC);
      push_res(24'd5);
      push_res(24'h0004FB);
      collect_tx("t5", 1'b0);
      check("t5_done_pulses", done_cnt - d0, 1);

      // Reset during TX returns everything to reset values; RESEND then sends zeros
      send_byte(8'hA3);
      check("t6_in_tx", tx_valid, 1'b1);
      send_byte(8'h00);
      check("t6_tx_overrun_err", err, 1'b1);
      RESET = 1'b1;
      #1;
      check("t6_rst_tx_valid", tx_valid, 1'b0);
      check("t6_rst_tx_data", tx_data, 8'h00);
      check("t6_rst_load_arr", load_arr, 1'b0);
      check("t6_rst_mult_done", mult_done, 1'b0);
      check("t6_rst_err", err, 1'b0);
      check("t6_rst_state", st, ST_IDLE);
      step();
      RESET = 1'b0;
      step();
      send_byte(8'hA3);
      for (int i = 0; i < 6; i++) exp_q.push_back(8'h00);
      collect_tx("t6", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/neural_mac_engine.md
# neural_mac_engine

Parametrised successor to the neural core datapath. Consumes a received UART byte stream and loads a ROWS×COLS weight matrix and a COLS-element input vector. Computes the matrix-vector product with one time-shared multiply-accumulate unit and streams the results back as bytes to the UART transmitter. It sits between the chip's UART RX/TX and the top-level status pins (load_arr, MULT_DONE, rx_error).

## Interface
- ROWS, default 2: output channels, 1..16
- COLS, default 2: vector length, 1..16
- SIGNED, default 0: 0 treats operands as unsigned 8-bit, 1 as two's complement
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- RX_DATA  in  8  received byte
- RX_VALID  in  1  one-cycle strobe, RX_DATA valid; no backpressure
- RX_ERROR  in  1  UART framing error strobe
- TX_DATA  out  8  result byte
- TX_VALID  out  1  TX_DATA valid; held until accepted
- TX_READY  in  1  transmitter accepts byte when TX_VALID&TX_READY
- LOAD_ARR  out  1  high while in LOAD_W or LOAD_X
- MULT_DONE  out  1  one-cycle pulse at end of compute
- ERR  out  1  sticky error flag

## Operation
- Widths: ACC_W = 16 + clog2(COLS) (min 17); RES_BYTES = ceil(ACC_W/8). Each result is sign- or zero-extended (per SIGNED) to RES_BYTES*8 bits and sent MSB byte first.
- Opcodes: 0xA1 LOAD_W, then ROWS*COLS bytes, row-major. 0xA2 LOAD_X, then COLS bytes; compute and transmit start automatically. 0xA3 RESEND, which retransmits the stored results.
- States:
  - IDLE: waits for an opcode. An unknown opcode sets ERR and stays in IDLE. A valid opcode clears ERR.
  - LOAD_W and LOAD_X: an index counter stores each byte. The last byte moves LOAD_W to IDLE and LOAD_X to MAC.
  - MAC: row and column counters; one product per cycle. The accumulator clears at column 0. The result is written to the result array at column COLS-1.
  - DONE: one cycle. MULT_DONE=1, then TX.
  - TX: walks ROWS*RES_BYTES bytes. Returns to IDLE after the last handshake.
- RESEND before any compute since reset transmits all zeros.
- RX_VALID in MAC, DONE or TX: byte dropped, ERR set (overrun).
- RX_ERROR in any state: ERR set. In LOAD_W or LOAD_X it also aborts to IDLE. A partially loaded array keeps its partially overwritten contents. A LOAD_X aborted by RX_ERROR starts no compute.
- RX_ERROR and RX_VALID in the same cycle: the byte is discarded and the RX_ERROR rule applies.
- Weights persist across multiple LOAD_X commands.

## Timing
- Reset values: TX_DATA=0, TX_VALID=0, LOAD_ARR=0, MULT_DONE=0, ERR=0, state IDLE, all counters 0, weight/input/result arrays 0.
- RESET asserted mid-operation returns to IDLE immediately. Any pending TX byte is lost.
- LOAD_ARR rises the cycle after the opcode is accepted. It falls the cycle after the last data byte.
- MAC latency: the final LOAD_X byte in cycle t gives MAC in cycles t+1..t+ROWS*COLS. MULT_DONE is at t+ROWS*COLS+1. The first TX_VALID is at t+ROWS*COLS+2.
- TX: TX_DATA is stable while TX_VALID=1 and TX_READY=0. The next byte is presented the cycle after the handshake, so one byte is sent per cycle with TX_READY held high.

## Structure
- Package neural_pkg: opcode constants (0xA1/0xA2/0xA3), state enum, and the ACC_W/RES_BYTES helper function.
- Sub-module neural_mac: registered 8×8 multiply (signed or unsigned per SIGNED) plus an ACC_W accumulator with clear and enable. The top holds the FSM, counters, arrays and TX serialiser.

## Test plan
- SIGNED=0, ROWS=COLS=2. Send A1 01 02 03 04, then A2 05 06 → MULT_DONE pulse; TX bytes 00 00 11 00 00 27 (17, 39).
- SIGNED=1. Send A1 FF 02 80 7F, then A2 80 7F → TX 00 01 7E 00 7F 01 (382, 32513).
- SIGNED=0, all 0xFF → each result 0x01FC02 and no overflow. Toggle TX_READY randomly → byte order unchanged and TX_DATA stable while stalled.
- Send opcode 0x55 → ERR=1, state IDLE. Then A3 → ERR=0 and the previous results are resent.
- RX_ERROR after 2 bytes of LOAD_W → ERR=1, LOAD_ARR falls, no MULT_DONE. A byte sent during MAC → dropped, ERR=1, result still correct.
- Assert RESET during TX → all outputs return to reset values. A following A3 sends zeros.
